logic_op_scheduler: RTL and testbench

Sequencer and arbiter that shares one WIDTH-bit bitwise logic unit between two requesters. Each requester submits operands and an opcode over a valid/ready handshake. The block picks a requester by round-robin, latches its operands, and evaluates one of seven bitwise functions (NOT, OR, NOR, AND, NAND, XOR, XNOR). It returns the registered result with the requester ID over a valid/ready response channel. It sits between the control logic issuing logic operations and the shared combinational logic unit.

---
 rtl/logic_op_pkg.sv | 33 +++
 rtl/logic_op_scheduler_logic_unit.sv | 32 +++
 rtl/logic_op_scheduler.sv | 141 ++++++++++++++
 tb/tb_logic_op_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op scheduler: opcode values, FSM state
// encoding and the round-robin pick helper.
package logic_op_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Winner ID between two requesters; prio only breaks ties.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic prio);
        logic id;
        if (v0 && v1) begin
            id = prio;
        end else begin
            id = v1;
        end
        return id;
    endfunction

endpackage

// File: rtl/logic_op_scheduler_logic_unit.sv
// Purely combinational bitwise logic unit shared by both requesters.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    output logic [WIDTH-1:0] y_out,
    output logic             err_out
);

    always_comb begin
        y_out   = '0;
        err_out = 1'b0;
        case (op_in)
            OP_NOT:  y_out = ~a_in;
            OP_OR:   y_out = a_in | b_in;
            OP_NOR:  y_out = ~(a_in | b_in);
            OP_AND:  y_out = a_in & b_in;
            OP_NAND: y_out = ~(a_in & b_in);
            OP_XOR:  y_out = a_in ^ b_in;
            OP_XNOR: y_out = ~(a_in ^ b_in);
            default: begin
                y_out   = '0;
                err_out = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one logic unit between two requesters;
// IDLE accepts, EXEC evaluates, RESP holds the result until taken.
module logic_op_scheduler
    import logic_op_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_in,

    input  logic             req0_valid_in,
    output logic             req0_ready_out,
    input  logic [WIDTH-1:0] req0_a_in,
    input  logic [WIDTH-1:0] req0_b_in,
    input  logic [2:0]       req0_op_in,

    input  logic             req1_valid_in,
    output logic             req1_ready_out,
    input  logic [WIDTH-1:0] req1_a_in,
    input  logic [WIDTH-1:0] req1_b_in,
    input  logic [2:0]       req1_op_in,

    output logic             rsp_valid_out,
    input  logic             rsp_ready_in,
    output logic             rsp_id_out,
    output logic [WIDTH-1:0] rsp_y_out,
    output logic             rsp_err_out,

    output logic             busy_out
);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;

    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] lu_y;
    logic             lu_err;

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .a_in    (a_q),
        .b_in    (b_q),
        .op_in   (op_q),
        .y_out   (lu_y),
        .err_out (lu_err)
    );

    // Reset wins over a same-cycle request, so acceptance is masked by rst_in.
    assign grant_id = rr_pick(req0_valid_in, req1_valid_in, prio_q);
    assign accept   = (state_q == IDLE) && (req0_valid_in || req1_valid_in) && !rst_in;

    assign req0_ready_out = accept && !grant_id;
    assign req1_ready_out = accept && grant_id;

    assign rsp_valid_out = rsp_valid_q;
    assign rsp_y_out     = rsp_y_q;
    assign rsp_id_out    = rsp_id_q;
    assign rsp_err_out   = rsp_err_q;
    assign busy_out      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant_id ? req1_a_in  : req0_a_in;
                    b_d     = grant_id ? req1_b_in  : req0_b_in;
                    op_d    = grant_id ? req1_op_in : req0_op_in;
                    id_d    = grant_id;
                    prio_d  = ~grant_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d     = lu_y;
                rsp_err_d   = lu_err;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            prio_q      <= PRIO_RESET;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Operand latches are only consumed after an accept, so they need no reset.
    always_ff @(posedge clk_in) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
        id_q <= id_d;
    end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed and randomized transaction bench for logic_op_scheduler against a
// transaction-level reference model (grant rule, priority flip, opcode table).
module tb_logic_op_scheduler;

    localparam int W = 4;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         req0_valid_in, req1_valid_in;
    logic         req0_ready_out, req1_ready_out;
    logic [W-1:0] req0_a_in, req0_b_in, req1_a_in, req1_b_in;
    logic [2:0]   req0_op_in, req1_op_in;
    logic         rsp_valid_out, rsp_ready_in, rsp_id_out, rsp_err_out, busy_out;
    logic [W-1:0] rsp_y_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit mprio;

    logic_op_scheduler #(
        .WIDTH      (W),
        .PRIO_RESET (1'b0)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req0_valid_in  (req0_valid_in),
        .req0_ready_out (req0_ready_out),
        .req0_a_in      (req0_a_in),
        .req0_b_in      (req0_b_in),
        .req0_op_in     (req0_op_in),
        .req1_valid_in  (req1_valid_in),
        .req1_ready_out (req1_ready_out),
        .req1_a_in      (req1_a_in),
        .req1_b_in      (req1_b_in),
        .req1_op_in     (req1_op_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_ready_in   (rsp_ready_in),
        .rsp_id_out     (rsp_id_out),
        .rsp_y_out      (rsp_y_out),
        .rsp_err_out    (rsp_err_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        logic [W-1:0] r;
        case (op)
            3'd0:    r = ~a;
            3'd1:    r = a | b;
            3'd2:    r = ~(a | b);
            3'd3:    r = a & b;
            3'd4:    r = ~(a & b);
            3'd5:    r = a ^ b;
            3'd6:    r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid_out, 0);
        chk({tag, "_rsp_y"}, rsp_y_out, 0);
        chk({tag, "_rsp_id"}, rsp_id_out, 0);
        chk({tag, "_rsp_err"}, rsp_err_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
    endtask

    // One full transaction from an IDLE cycle: offer, accept, EXEC, RESP (with stall), back to IDLE.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] o0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] o1,
                           input int stall);
        bit           gid;
        logic [W-1:0] ey;
        logic         eerr;
        req0_valid_in = v0; req0_a_in = a0; req0_b_in = b0; req0_op_in = o0;
        req1_valid_in = v1; req1_a_in = a1; req1_b_in = b1; req1_op_in = o1;
        #1;
        if (!v0 && !v1) begin
            chk("idle_ready0", req0_ready_out, 0);
            chk("idle_ready1", req1_ready_out, 0);
            tick();
            chk("idle_busy", busy_out, 0);
            chk("idle_rsp_valid", rsp_valid_out, 0);
            return;
        end
        gid  = (v0 && v1) ? mprio : v1;
        ey   = gid ? ref_y(a1, b1, o1) : ref_y(a0, b0, o0);
        eerr = gid ? (o1 == 3'd7) : (o0 == 3'd7);
        chk("accept_ready0", req0_ready_out, !gid);
        chk("accept_ready1", req1_ready_out, gid);
        tick();
        mprio = ~gid;
        // Scramble requester inputs: they must no longer affect the operation.
        req0_valid_in = 1'b1; req1_valid_in = 1'b1;
        req0_a_in = W'($urandom); req0_b_in = W'($urandom); req0_op_in = 3'($urandom);
        req1_a_in = W'($urandom); req1_b_in = W'($urandom); req1_op_in = 3'($urandom);
        rsp_ready_in = (stall == 0);
        #1;
        chk("exec_busy", busy_out, 1);
        chk("exec_rsp_valid", rsp_valid_out, 0);
        chk("exec_ready0", req0_ready_out, 0);
        chk("exec_ready1", req1_ready_out, 0);
        tick();
        chk("resp_valid", rsp_valid_out, 1);
        chk("resp_y", rsp_y_out, ey);
        chk("resp_id", rsp_id_out, gid);
        chk("resp_err", rsp_err_out, eerr);
        chk("resp_busy", busy_out, 1);
        chk("resp_ready0", req0_ready_out, 0);
        chk("resp_ready1", req1_ready_out, 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", rsp_valid_out, 1);
            chk("stall_y", rsp_y_out, ey);
            chk("stall_id", rsp_id_out, gid);
            chk("stall_busy", busy_out, 1);
            chk("stall_ready0", req0_ready_out, 0);
            chk("stall_ready1", req1_ready_out, 0);
        end
        rsp_ready_in = 1'b1;
        tick();
        chk("done_rsp_valid", rsp_valid_out, 0);
        chk("done_busy", busy_out, 0);
        req0_valid_in = 1'b0;
        req1_valid_in = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_tab [7];
        exp_tab = '{4'b1001, 4'b0111, 4'b1000, 4'b0010, 4'b1101, 4'b0101, 4'b1010};

        rst_in = 1'b1;
        req0_valid_in = 1'b1; req1_valid_in = 1'b1;
        req0_a_in = '0; req0_b_in = '0; req0_op_in = '0;
        req1_a_in = '0; req1_b_in = '0; req1_op_in = '0;
        rsp_ready_in = 1'b0;
        tick();
        tick();
        chk("rst_ready0", req0_ready_out, 0);
        chk("rst_ready1", req1_ready_out, 0);
        check_reset_outputs("rst");
        rst_in = 1'b0;
        req0_valid_in = 1'b0; req1_valid_in = 1'b0;
        mprio = 1'b0;

        // Single request: 1100 & 1010 = 1000.
        run_txn(1, 0, 4'b1100, 4'b1010, 3'd3, 4'h0, 4'h0, 3'd0, 0);

        // Opcode table against independently listed constants, then reserved opcode.
        for (int op = 0; op < 7; op++) begin
            chk("table_model", ref_y(4'b0110, 4'b0011, 3'(op)), exp_tab[op]);
            run_txn(1, 0, 4'b0110, 4'b0011, 3'(op), 4'h0, 4'h0, 3'd0, 0);
        end
        run_txn(0, 1, 4'h0, 4'h0, 3'd0, 4'b0110, 4'b0011, 3'd7, 0);

        // Backpressure: five stalled RESP cycles.
        run_txn(0, 1, 4'h0, 4'h0, 3'd0, 4'b1111, 4'b0101, 3'd5, 5);

        // Reset during EXEC drops the transaction.
        req1_valid_in = 1'b1; req1_a_in = 4'b0000; req1_b_in = 4'b0000; req1_op_in = 3'd0;
        #1;
        chk("mid_accept", req1_ready_out, 1);
        tick();
        rst_in = 1'b1;
        req1_valid_in = 1'b0;
        tick();
        rst_in = 1'b0;
        mprio = 1'b0;
        check_reset_outputs("mid_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_rsp", rsp_valid_out, 0);
        end
        run_txn(1, 0, 4'b0011, 4'b0101, 3'd1, 4'h0, 4'h0, 3'd0, 0);

        // Contention after fresh reset: grants alternate 0,1,0,1 back to back.
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        mprio = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("cont_prio", mprio, i % 2);
            run_txn(1, 1, 4'h3, 4'h5, 3'd5, 4'hC, 4'h6, 3'd3, 0);
        end

        // Randomized transactions.
        for (int n = 0; n < 150; n++) begin
            run_txn(1'($urandom), 1'($urandom),
                    W'($urandom), W'($urandom), 3'($urandom),
                    W'($urandom), W'($urandom), 3'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
